// File: rtl/mvu_ic_pkg.sv
// Shared definitions for the MVU interconnect transfer controller.
//   BDBANKA - data-bank address width
//   BDBANKW - data-bank word width
//   idx_w() - bits needed to index one of n MVUs (at least 1)
//   xfer_state_e - controller states IDLE/CFG/RUN/DRAIN/DONE
package mvu_ic_pkg;

    localparam int BDBANKA = 14;
    localparam int BDBANKW = 64;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        RUN,
        DRAIN,
        DONE
    } xfer_state_e;

endpackage

// File: rtl/ic_xfer_dly.sv
// Commit-flag delay line matching the interconnect pipeline depth.
//   clk, rst     - clock, synchronous active-high reset
//   commit_i     - a read beat committed this cycle
//   commit_o     - the commit issued LAT cycles ago arrives at the destinations now
//   in_flight_o  - a commit is still in the pipe beyond the one arriving now
module ic_xfer_dly #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic commit_i,
    output logic commit_o,
    output logic in_flight_o
);

    // Every stage except the output stage; empty when LAT is 1.
    localparam logic [LAT-1:0] BODY = (LAT'(1) << (LAT - 1)) - LAT'(1);

    logic [LAT-1:0] sr_q;

    // NOTE: the pipe is reset, not left as plain storage: a reset must
    // discard commits still travelling, or a stale arrival would advance
    // the write address of the next transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= (sr_q << 1) | LAT'(commit_i);
        end
    end

    assign commit_o    = sr_q[LAT-1];
    // Excluding the output stage lets DRAIN last exactly as long as the
    // last commit needs to reach the destinations.
    assign in_flight_o = |(sr_q & BODY);

endmodule

// File: rtl/ic_xfer_ctl.sv
// Sequences one inter-MVU transfer: programs the interconnect routing,
// issues source reads until every beat is fully granted, and produces the
// destination write address aligned with arriving words.
//   clk, rst           - clock, synchronous active-high reset
//   cmd_*              - command handshake and fields (perm, dst mask, bases, len)
//   ic_clr             - interconnect clear pulse (CFG cycle)
//   ic_recv_from       - routing, held from CFG until the next command
//   rdi_en/grnt/addr   - interconnect-side reads on the source MVUs
//   wri_grnt/addr      - destination write grant / write address
//   busy, done, err    - status; err is sticky until reset or next accept
// Optional build macro IC_XFER_TIMEOUT_EN adds a stall timeout (TOW bits).
module ic_xfer_ctl
    import mvu_ic_pkg::*;
#(
    parameter int N       = 8,
    parameter int BDBANKA = mvu_ic_pkg::BDBANKA,
    parameter int LAT     = 2,
    parameter int LENW    = 14
`ifdef IC_XFER_TIMEOUT_EN
    ,
    parameter int TOW     = 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [N*idx_w(N)-1:0] cmd_perm,
    input  logic [N-1:0]          cmd_dst_mask,
    input  logic [BDBANKA-1:0]    cmd_rd_base,
    input  logic [BDBANKA-1:0]    cmd_wr_base,
    input  logic [LENW-1:0]       cmd_len,
    output logic                  ic_clr,
    output logic [N*idx_w(N)-1:0] ic_recv_from,
    output logic [N-1:0]          rdi_en,
    input  logic [N-1:0]          rdi_grnt,
    output logic [N*BDBANKA-1:0]  rdi_addr,
    input  logic [N-1:0]          wri_grnt,
    output logic [N*BDBANKA-1:0]  wri_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int IW = idx_w(N);

    xfer_state_e        state_q, state_d;
    logic [N*IW-1:0]    perm_q, recv_q;
    logic [N-1:0]       mask_q, src_q, src_d;
    logic [BDBANKA-1:0] rd_base_q, wr_base_q, rd_addr, wr_addr;
    logic [LENW-1:0]    len_q, cnt_q, wcnt_q;
    logic               err_q, accept, commit, last_beat, dly_commit, in_flight;
    logic               wr_short, timeout;

    // Sources feeding at least one participating destination.
    always_comb begin
        src_d = '0;
        for (int d = 0; d < N; d++) begin
            if (cmd_dst_mask[d]) src_d[cmd_perm[d*IW +: IW]] = 1'b1;
        end
    end

    assign accept    = (state_q == IDLE) && cmd_valid;
    // A beat counts only when every source granted; an empty source set
    // therefore commits on every RUN cycle.
    assign commit    = (state_q == RUN) && ((rdi_grnt & src_q) == src_q);
    assign last_beat = commit && ((cnt_q + LENW'(1)) == len_q);
    assign wr_short  = dly_commit && ((wri_grnt & mask_q) != mask_q);

`ifdef IC_XFER_TIMEOUT_EN
    localparam logic [TOW-1:0] TO_LAST = {{(TOW-1){1'b1}}, 1'b0};

    logic [TOW-1:0] stall_q;

    // Fires on the stall cycle that brings the run of misses to 2^TOW-1.
    assign timeout = (state_q == RUN) && !commit && (stall_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst || state_q == CFG || commit) begin
            stall_q <= '0;
        end else if (state_q == RUN) begin
            stall_q <= stall_q + TOW'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // NOTE: every output and state_d gets a default before the case so no
    // path leaves a value unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        ic_clr    = 1'b0;
        rdi_en    = '0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_d = CFG;
            end
            CFG: begin
                ic_clr  = 1'b1;
                state_d = (len_q == '0) ? DONE : RUN;
            end
            RUN: begin
                rdi_en = src_q;
                if (last_beat || timeout) state_d = DRAIN;
            end
            DRAIN: begin
                if (!in_flight) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            perm_q    <= '0;
            recv_q    <= '0;
            mask_q    <= '0;
            src_q     <= '0;
            rd_base_q <= '0;
            wr_base_q <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                perm_q    <= cmd_perm;
                mask_q    <= cmd_dst_mask;
                src_q     <= src_d;
                rd_base_q <= cmd_rd_base;
                wr_base_q <= cmd_wr_base;
                len_q     <= cmd_len;
                cnt_q     <= '0;
                wcnt_q    <= '0;
            end
            if (state_q == CFG) recv_q <= perm_q;
            if (commit)         cnt_q  <= cnt_q + LENW'(1);
            // Only committed arrivals advance the write address; a duplicate
            // word rewrites the address of the beat it repeats.
            if (dly_commit)     wcnt_q <= wcnt_q + LENW'(1);
            if (accept) begin
                err_q <= 1'b0;
            end else if (wr_short || timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    ic_xfer_dly #(
        .LAT(LAT)
    ) u_dly (
        .clk        (clk),
        .rst        (rst),
        .commit_i   (commit),
        .commit_o   (dly_commit),
        .in_flight_o(in_flight)
    );

    assign rd_addr      = rd_base_q + BDBANKA'(cnt_q);
    assign wr_addr      = wr_base_q + BDBANKA'(wcnt_q);
    assign rdi_addr     = {N{rd_addr}};
    assign wri_addr     = {N{wr_addr}};
    assign ic_recv_from = recv_q;
    assign err          = err_q;

endmodule

// File: tb/tb_ic_xfer_ctl.sv
module tb_ic_xfer_ctl;

    localparam int N    = 8;
    localparam int IW   = 3;
    localparam int PW   = N * IW;
    localparam int BA   = 14;
    localparam int LAT  = 2;
    localparam int LENW = 14;
    localparam int MAXC = 64;
    localparam logic [PW-1:0] IDENT = 24'hFAC688;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [PW-1:0]   cmd_perm;
    logic [N-1:0]    cmd_dst_mask;
    logic [BA-1:0]   cmd_rd_base, cmd_wr_base;
    logic [LENW-1:0] cmd_len;
    logic            ic_clr;
    logic [PW-1:0]   ic_recv_from;
    logic [N-1:0]    rdi_en, rdi_grnt, wri_grnt;
    logic [N*BA-1:0] rdi_addr, wri_addr;
    logic            busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ic_xfer_ctl #(
        .N(N), .BDBANKA(BA), .LAT(LAT), .LENW(LENW)
`ifdef IC_XFER_TIMEOUT_EN
        , .TOW(4)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_perm(cmd_perm), .cmd_dst_mask(cmd_dst_mask),
        .cmd_rd_base(cmd_rd_base), .cmd_wr_base(cmd_wr_base), .cmd_len(cmd_len),
        .ic_clr(ic_clr), .ic_recv_from(ic_recv_from),
        .rdi_en(rdi_en), .rdi_grnt(rdi_grnt), .rdi_addr(rdi_addr),
        .wri_grnt(wri_grnt), .wri_addr(wri_addr),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [PW-1:0]   perm;
        logic [N-1:0]    mask;
        logic [BA-1:0]   rd_base;
        logic [BA-1:0]   wr_base;
        logic [LENW-1:0] len;
        int              stall_run;  // RUN-cycle index with rdi_grnt bit dropped, -1 none
        int              stall_bit;
        int              wdrop_idx;  // 1-based delayed commit with wri_grnt bit dropped, 0 none
        int              wdrop_bit;
        int              exp_done;   // expected done cycle after accept, -1 unchecked
        bit              exp_err;
    } vec_t;

    function automatic vec_t mk(logic [PW-1:0] p, logic [N-1:0] m, logic [BA-1:0] rb,
                                logic [BA-1:0] wb, logic [LENW-1:0] l, int sr, int sb,
                                int wi, int wbit, int ed, bit ee);
        vec_t v;
        v.perm = p; v.mask = m; v.rd_base = rb; v.wr_base = wb; v.len = l;
        v.stall_run = sr; v.stall_bit = sb; v.wdrop_idx = wi; v.wdrop_bit = wbit;
        v.exp_done = ed; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one transfer starting at a negedge with the DUT idle. Expected
    // traces come from the transfer rules: one read per RUN cycle at
    // rd_base+beat, a beat advances only on a full source grant, every read
    // lands LAT cycles later at wr_base+(beats landed so far), then LAT drain
    // cycles and a done cycle follow the last beat.
    task automatic do_xfer(input vec_t v, input bit rnd);
        logic [N-1:0]    g_rd [MAXC];
        logic [N-1:0]    g_wr [MAXC];
        logic [N-1:0]    e_rden [MAXC];
        logic [BA-1:0]   e_rda [MAXC];
        logic [BA-1:0]   e_wra [MAXC];
        bit              e_rdv [MAXC];
        bit              e_wrv [MAXC];
        bit              cmt [MAXC];
        int              ctimes[$];
        logic [N-1:0]    src;
        logic [N*BA-1:0] rep;
        int              t, k, nland, tl, done_t, seen_done;
        bit              e_err;

        for (int c = 0; c < MAXC; c++) begin
            g_rd[c] = '1; g_wr[c] = '1; e_rden[c] = '0; e_rda[c] = '0; e_wra[c] = '0;
            e_rdv[c] = 0; e_wrv[c] = 0; cmt[c] = 0;
            if (rnd) begin
                if ((c % 4 != 3) && ($urandom_range(3) == 0)) g_rd[c] = N'($urandom);
                if ($urandom_range(7) == 0) g_wr[c] = N'($urandom);
            end
        end
        if (v.stall_run >= 0) g_rd[2 + v.stall_run][v.stall_bit] = 1'b0;

        src = '0;
        for (int d = 0; d < N; d++) begin
            if (v.mask[d]) src[int'(v.perm[d*IW +: IW])] = 1'b1;
        end

        e_err = 0;
        if (v.len == '0) begin
            done_t = 2;
        end else begin
            t = 2;
            k = 0;
            while (k < int'(v.len) && t < MAXC - LAT - 3) begin
                e_rden[t] = src;
                e_rdv[t]  = 1;
                e_rda[t]  = v.rd_base + BA'(k);
                if ((g_rd[t] & src) == src) begin
                    cmt[t] = 1;
                    ctimes.push_back(t);
                    k++;
                end
                t++;
            end
            tl     = t - 1;
            done_t = tl + LAT + 1;
            if (v.wdrop_idx > 0 && v.wdrop_idx <= ctimes.size())
                g_wr[ctimes[v.wdrop_idx-1] + LAT][v.wdrop_bit] = 1'b0;
            nland = 0;
            for (int r = 2; r <= tl; r++) begin
                e_wrv[r+LAT] = 1;
                e_wra[r+LAT] = v.wr_base + BA'(nland);
                if (cmt[r]) begin
                    if ((g_wr[r+LAT] & v.mask) != v.mask) e_err = 1;
                    nland++;
                end
            end
        end

        seen_done = -1;
        for (int c = 0; c <= done_t + 1; c++) begin
            check($sformatf("cmd_ready@%0d", c), 128'(cmd_ready), 128'(c == 0 || c == done_t + 1));
            check($sformatf("busy@%0d", c), 128'(busy), 128'(c >= 1 && c <= done_t));
            check($sformatf("done@%0d", c), 128'(done), 128'(c == done_t));
            check($sformatf("ic_clr@%0d", c), 128'(ic_clr), 128'(c == 1));
            check($sformatf("rdi_en@%0d", c), 128'(rdi_en), 128'(e_rden[c]));
            if (done === 1'b1 && seen_done < 0) seen_done = c;
            if (e_rdv[c]) begin
                rep = {N{e_rda[c]}};
                check($sformatf("rdi_addr@%0d", c), 128'(rdi_addr), 128'(rep));
            end
            if (e_wrv[c]) begin
                rep = {N{e_wra[c]}};
                check($sformatf("wri_addr@%0d", c), 128'(wri_addr), 128'(rep));
            end
            if (c >= 2) check($sformatf("ic_recv_from@%0d", c), 128'(ic_recv_from), 128'(v.perm));
            if (c == 1) check("err_cleared", 128'(err), 128'(0));
            if (c >= done_t) check($sformatf("err@%0d", c), 128'(err), 128'(e_err));
            if (c == done_t + 1) begin
                cmd_valid = 1'b0;
                break;
            end
            if (c == 0) begin
                cmd_valid    = 1'b1;
                cmd_perm     = v.perm;
                cmd_dst_mask = v.mask;
                cmd_rd_base  = v.rd_base;
                cmd_wr_base  = v.wr_base;
                cmd_len      = v.len;
            end else begin
                // Commands offered while busy must be ignored.
                cmd_valid    = 1'($urandom);
                cmd_perm     = PW'($urandom);
                cmd_dst_mask = N'($urandom);
                cmd_rd_base  = BA'($urandom);
                cmd_wr_base  = BA'($urandom);
                cmd_len      = LENW'($urandom_range(9));
            end
            rdi_grnt = g_rd[c];
            wri_grnt = g_wr[c];
            step();
        end

        if (v.exp_done >= 0) begin
            check("tbl_done_cycle", 128'(seen_done), 128'(v.exp_done));
            check("tbl_err", 128'(err), 128'(v.exp_err));
        end
        rdi_grnt = '1;
        wri_grnt = '1;
        if (cmd_ready !== 1'b1) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, 128'(cmd_ready), 128'(1));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_err"}, 128'(err), 128'(0));
        check({tag, "_ic_clr"}, 128'(ic_clr), 128'(0));
        check({tag, "_rdi_en"}, 128'(rdi_en), 128'(0));
        check({tag, "_ic_recv_from"}, 128'(ic_recv_from), 128'(0));
        check({tag, "_rdi_addr"}, 128'(rdi_addr), 128'(0));
        check({tag, "_wri_addr"}, 128'(wri_addr), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[10];
    vec_t rv;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_perm = '0; cmd_dst_mask = '0;
        cmd_rd_base = '0; cmd_wr_base = '0; cmd_len = '0;
        rdi_grnt = '1; wri_grnt = '1;

        //            perm   mask   rd_base  wr_base  len  stall  sbit wdrop wbit done err
        tbl[0] = mk(IDENT, 8'hFF, 14'h10,   14'h40,   4,   -1,    0,   0,    0,   8,   0);
        tbl[1] = mk(IDENT, 8'hFF, 14'h10,   14'h40,   4,    1,    3,   0,    0,   9,   0);
        tbl[2] = mk(IDENT, 8'hFF, 14'h10,   14'h40,   4,   -1,    0,   3,    5,   8,   1);
        tbl[3] = mk(IDENT, 8'hFF, 14'h10,   14'h40,   4,   -1,    0,   0,    0,   8,   0);
        tbl[4] = mk(IDENT, 8'hFF, 14'h10,   14'h40,   0,   -1,    0,   0,    0,   2,   0);
        tbl[5] = mk(IDENT, 8'hFF, 14'h3FFF, 14'h0,    2,   -1,    0,   0,    0,   6,   0);
        tbl[6] = mk(IDENT, 8'h00, 14'h10,   14'h40,   3,   -1,    0,   2,    1,   7,   0);
        tbl[7] = mk(24'h0, 8'h0F, 14'h20,   14'h30,   4,    0,    5,   0,    0,   8,   0);
        tbl[8] = mk(IDENT, 8'h0F, 14'h10,   14'h40,   4,   -1,    0,   1,    6,   8,   0);
        tbl[9] = mk(IDENT, 8'hFF, 14'h100,  14'h3FFE, 3,   -1,    0,   0,    0,   7,   0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) do_xfer(tbl[i], 1'b0);

        // Reset in the middle of RUN abandons the transfer at once.
        cmd_valid = 1'b1; cmd_perm = IDENT; cmd_dst_mask = 8'hFF;
        cmd_rd_base = 14'h55; cmd_wr_base = 14'h66; cmd_len = 14'd8;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check("midrun_rdi_en_active", 128'(rdi_en), 128'(8'hFF));
        rst = 1'b1;
        step();
        check_reset_values("midrun");
        rst = 1'b0;
        do_xfer(tbl[0], 1'b0);

`ifdef IC_XFER_TIMEOUT_EN
        begin
            int seen;
            seen = -1;
            cmd_valid = 1'b1; cmd_perm = IDENT; cmd_dst_mask = 8'hFF;
            cmd_rd_base = 14'h10; cmd_wr_base = 14'h40; cmd_len = 14'd3;
            rdi_grnt = '0;
            step();
            cmd_valid = 1'b0;
            for (int c = 1; c < 40; c++) begin
                if (done === 1'b1 && seen < 0) seen = c;
                step();
            end
            // 15 stall cycles starting at cycle 2, one DRAIN cycle, then DONE.
            check("timeout_done_cycle", 128'(seen), 128'(18));
            check("timeout_err", 128'(err), 128'(1));
            rdi_grnt = '1;
        end
`endif

        for (int i = 0; i < 40; i++) begin
            rv = mk(PW'($urandom), N'($urandom), BA'($urandom), BA'($urandom),
                    LENW'($urandom_range(10)), -1, 0, 0, 0, -1, 0);
            if ($urandom_range(3) == 0) rv.mask = 8'hFF;
            if ($urandom_range(7) == 0) rv.mask = 8'h00;
            do_xfer(rv, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
